// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the multi-cycle FP datapath (adder and float-to-int converter).
package fp_pkg;

    localparam int FP32_EXP_BIAS = 127;
    localparam int FP32_EXP_W    = 8;
    localparam int FP32_MAN_W    = 23;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    // N and Z always come from the final integer, C and V from the conversion path.
    function automatic logic [3:0] make_flags(input logic [31:0] res, input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = res[31];
        f[FLAG_Z] = (res == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational IEEE-754 single-precision operand classifier, shared by the FP adder and converter.
module fp32_classify
    import fp_pkg::*;
(
    input  logic [FP32_EXP_W-1:0] exp_f,
    input  logic [FP32_MAN_W-1:0] man,
    output logic                  is_zero,
    output logic                  is_denorm,
    output logic                  is_inf,
    output logic                  is_nan,
    output logic                  is_normal
);

    logic exp_min;
    logic exp_max;
    logic man_nz;

    assign exp_min = (exp_f == '0);
    assign exp_max = (exp_f == '1);
    assign man_nz  = (man != '0);

    assign is_zero   = exp_min & ~man_nz;
    assign is_denorm = exp_min &  man_nz;
    assign is_inf    = exp_max & ~man_nz;
    assign is_nan    = exp_max &  man_nz;
    assign is_normal = ~exp_min & ~exp_max;

endmodule

// File: rtl/fp32_to_int32_seq.sv
// Multi-cycle FP32 -> signed INT32 converter; alignment shifts one bit per cycle.
// Build option ROUND_NEAREST_EN selects round-to-nearest-even; otherwise truncates toward zero.
module fp32_to_int32_seq
    import fp_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic        busy,
    output logic        done
);

`ifdef ROUND_NEAREST_EN
    localparam logic [7:0] MIN_EXP = 8'(FP32_EXP_BIAS - 1);
`else
    localparam logic [7:0] MIN_EXP = 8'(FP32_EXP_BIAS);
`endif
    localparam logic [7:0] SAT_EXP = 8'(FP32_EXP_BIAS + 31);

    conv_state_t state, state_next;

    logic             sign;
    logic [31:0]      mag;
    logic             guard;
    logic             sticky;
    logic [CNT_W-1:0] cnt;

    logic        is_zero, is_denorm, is_inf, is_nan, is_normal;
    logic [7:0]  exp_in;
    logic [7:0]  shift_n;
    logic        special;
    logic [31:0] special_result;
    logic        special_c;
    logic        special_v;
    logic        round_up;
    logic [31:0] rounded;
    logic [31:0] final_result;

    assign exp_in  = a[30:23];
    assign shift_n = SAT_EXP - exp_in;

    fp32_classify u_classify (
        .exp_f     (a[30:23]),
        .man       (a[22:0]),
        .is_zero   (is_zero),
        .is_denorm (is_denorm),
        .is_inf    (is_inf),
        .is_nan    (is_nan),
        .is_normal (is_normal)
    );

    // Operands that resolve in a single cycle without iterative alignment.
    always_comb begin
        special        = 1'b1;
        special_result = '0;
        special_c      = 1'b0;
        special_v      = 1'b0;
        if (is_nan) begin
            special_v = 1'b1;
        end else if (is_inf || exp_in >= SAT_EXP) begin
            special_result = a[31] ? INT32_MIN : INT32_MAX;
            special_v      = (a != 32'hCF00_0000);
        end else if (is_zero || is_denorm) begin
            special_c = is_denorm;
        end else if (is_normal && exp_in < MIN_EXP) begin
            special_c = 1'b1;
        end else begin
            special = 1'b0;
        end
    end

`ifdef ROUND_NEAREST_EN
    assign round_up = guard & (sticky | mag[0]);
`else
    assign round_up = 1'b0;
`endif
    assign rounded      = mag + {31'b0, round_up};
    assign final_result = sign ? (~rounded + 32'd1) : rounded;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = special ? DONE : SHIFT;
            SHIFT:   if (cnt == CNT_W'(1)) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Each shift moves the old guard into sticky so sticky covers every bit below the guard.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            flags  <= '0;
            sign   <= 1'b0;
            mag    <= '0;
            guard  <= 1'b0;
            sticky <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign   <= a[31];
                        mag    <= {1'b1, a[22:0], 8'b0};
                        guard  <= 1'b0;
                        sticky <= 1'b0;
                        cnt    <= CNT_W'(shift_n);
                        if (special) begin
                            result <= special_result;
                            flags  <= make_flags(special_result, special_c, special_v);
                        end
                    end
                end
                SHIFT: begin
                    mag    <= mag >> 1;
                    guard  <= mag[0];
                    sticky <= sticky | guard;
                    cnt    <= cnt - CNT_W'(1);
                end
                ROUND: begin
                    result <= final_result;
                    flags  <= make_flags(final_result, guard | sticky, 1'b0);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SHIFT) || (state == ROUND);
    assign done = (state == DONE);

endmodule
